// File: rtl/pipeline_trace_pkg.sv
// Shared types for the retire-stage trace monitor.
// Holds the capture FSM states, the MODE encodings, the trace record payload and
// a saturating counter helper. Record fields are sized for the widest supported
// configuration (PC and data up to 64 bits, timestamp up to 32 bits); narrower
// instances zero-extend on entry and truncate on exit.
package pipeline_trace_pkg;

    localparam int unsigned REC_PC_W = 64;
    localparam int unsigned REC_XLEN = 64;
    localparam int unsigned REC_TS_W = 32;
    localparam int unsigned MODE_W   = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ALL   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_WATCH = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TRIG  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [REC_PC_W-1:0] pc;
        logic                rd_we;
        logic [4:0]          rd_addr;
        logic [REC_XLEN-1:0] rd_data;
        logic [REC_TS_W-1:0] ts;
    } trace_rec_t;

    // Increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pipeline_trace_if.sv
// Bundle of the retire-stage taps, capture controls and trace drain port.
// slave  : the monitor side (taps/controls in, drained record and status out)
// master : the pipeline/consumer side (the mirror image)
interface pipeline_trace_if
    import pipeline_trace_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TS_W  = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              EN;
    logic [MODE_W-1:0] MODE;
    logic [PC_W-1:0]   TRIG_PC;
    logic              RET_VALID;
    logic [PC_W-1:0]   RET_PC;
    logic              RD_WE;
    logic [4:0]        RD_ADDR;
    logic [XLEN-1:0]   RD_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [PC_W-1:0]   OUT_PC;
    logic              OUT_RD_WE;
    logic [4:0]        OUT_RD_ADDR;
    logic [XLEN-1:0]   OUT_RD_DATA;
    logic [TS_W-1:0]   OUT_TS;
    logic [LVL_W-1:0]  LEVEL;
    logic [7:0]        OVERFLOW_CNT;
    logic              TRIGGERED;

    modport slave (
        input  EN, MODE, TRIG_PC, RET_VALID, RET_PC, RD_WE, RD_ADDR, RD_DATA, OUT_READY,
        output OUT_VALID, OUT_PC, OUT_RD_WE, OUT_RD_ADDR, OUT_RD_DATA, OUT_TS,
               LEVEL, OVERFLOW_CNT, TRIGGERED
    );

    modport master (
        output EN, MODE, TRIG_PC, RET_VALID, RET_PC, RD_WE, RD_ADDR, RD_DATA, OUT_READY,
        input  OUT_VALID, OUT_PC, OUT_RD_WE, OUT_RD_ADDR, OUT_RD_DATA, OUT_TS,
               LEVEL, OVERFLOW_CNT, TRIGGERED
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for trace records.
// Ports: clk, rst_n (async active-low), push/push_data (write request; ignored when
// full unless a pop happens in the same cycle), pop (ignored when empty),
// head_c (record at the read pointer, straight from storage), empty_c/full_c
// (decoded from the level register), level (registered occupancy).
module trace_fifo
    import pipeline_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         T     = trace_rec_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head_c,
    output logic                   empty_c,
    output logic                   full_c,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LW'(DEPTH));
    assign head_c  = mem_q[rd_ptr_q];
    assign level   = level_q;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop_ok   = pop && !empty_c;
        push_ok  = push && (!full_c || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level register alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// Retire-stage trace monitor.
// Snoops the retire taps (PC, rd write), registers them once, filters them by
// capture mode and buffers the surviving records in trace_fifo, drained through a
// valid/ready port.
// Ports: CLK; RST (async active-low); bus (slave modport of pipeline_trace_if):
// EN/MODE/TRIG_PC capture controls, RET_*/RD_* retire taps, OUT_* head record with
// OUT_VALID/OUT_READY handshake, LEVEL occupancy, OVERFLOW_CNT saturating drop
// count, TRIGGERED (high in CAPTURE or FROZEN).
// PC_W and XLEN up to 64, TS_W up to 32.
module pipeline_trace_monitor
    import pipeline_trace_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WATCH_REGS = 6,
    parameter int unsigned TS_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipeline_trace_if.slave   bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ovf_q, ovf_d;
    logic              trig_q, trig_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              ret_valid_q, ret_valid_d;
    trace_rec_t        rec_q, rec_d;

    logic              trig_hit_c;
    logic              qual_c;
    logic              push_c;
    logic              pop_c;
    logic              accept_c;
    trace_rec_t        head_c;
    logic              empty_c;
    logic              full_c;
    logic [LVL_W-1:0]  level;

    // Input register stage; the timestamp travels with the retire it belongs to.
    always_comb begin
        ret_valid_d     = bus.RET_VALID;
        rec_d           = '0;
        rec_d.pc        = REC_PC_W'(bus.RET_PC);
        rec_d.rd_we     = bus.RD_WE;
        rec_d.rd_addr   = bus.RD_ADDR;
        rec_d.rd_data   = REC_XLEN'(bus.RD_DATA);
        rec_d.ts        = REC_TS_W'(ts_q);
        ts_d            = ts_q + TS_W'(1);
    end

    // Qualify the registered retire and decide push/pop for this cycle.
    always_comb begin
        trig_hit_c = ret_valid_q && (rec_q.pc == REC_PC_W'(bus.TRIG_PC));
        qual_c     = 1'b0;
        case (mode_q)
            MODE_ALL, MODE_TRIG: qual_c = ret_valid_q;
            MODE_WATCH: qual_c = ret_valid_q && rec_q.rd_we
                                 && ({1'b0, rec_q.rd_addr} < 6'(WATCH_REGS))
                                 && (rec_q.rd_addr != 5'd0);
            default:    qual_c = 1'b0;
        endcase
        // The trigger retire itself is recorded on the ARMED->CAPTURE step.
        push_c   = ((state_q == ST_CAPTURE) && qual_c)
                   || ((state_q == ST_ARMED) && trig_hit_c);
        pop_c    = !empty_c && bus.OUT_READY;
        accept_c = push_c && (!full_c || pop_c);
    end

    // Capture FSM, post-trigger record count and drop counter.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (push_c && !accept_c) begin
            ovf_d = sat_inc8(ovf_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.EN) begin
                    if ((bus.MODE == MODE_ALL) || (bus.MODE == MODE_WATCH)) begin
                        state_d = ST_CAPTURE;
                        mode_d  = bus.MODE;
                    end else if (bus.MODE == MODE_TRIG) begin
                        state_d = ST_ARMED;
                        mode_d  = bus.MODE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ARMED: begin
                if (trig_hit_c) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = LVL_W'(accept_c);
                end
            end
            ST_CAPTURE: begin
                // Only accepted records count toward the post-trigger window.
                if ((mode_q == MODE_TRIG) && accept_c) begin
                    cnt_d = cnt_q + LVL_W'(1);
                    if (cnt_q == LVL_W'(DEPTH - 1)) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase

        // Disable, MODE_OFF or a mode switch always re-enters through IDLE.
        if ((state_q != ST_IDLE)
            && (!bus.EN || (bus.MODE == MODE_OFF) || (bus.MODE != mode_q))) begin
            state_d = ST_IDLE;
        end

        trig_d = (state_d == ST_CAPTURE) || (state_d == ST_FROZEN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OFF;
            cnt_q       <= '0;
            ovf_q       <= '0;
            trig_q      <= 1'b0;
            ts_q        <= '0;
            ret_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            trig_q      <= trig_d;
            ts_q        <= ts_d;
            ret_valid_q <= ret_valid_d;
            rec_q       <= rec_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push_c),
        .push_data (rec_q),
        .pop       (pop_c),
        .head_c    (head_c),
        .empty_c   (empty_c),
        .full_c    (full_c),
        .level     (level)
    );

    assign bus.OUT_VALID    = !empty_c;
    assign bus.LEVEL        = level;
    assign bus.OVERFLOW_CNT = ovf_q;
    assign bus.TRIGGERED    = trig_q;

    // Head fields read as zero while the FIFO is empty (storage is not reset).
    always_comb begin
        bus.OUT_PC      = '0;
        bus.OUT_RD_WE   = 1'b0;
        bus.OUT_RD_ADDR = '0;
        bus.OUT_RD_DATA = '0;
        bus.OUT_TS      = '0;
        if (!empty_c) begin
            bus.OUT_PC      = PC_W'(head_c.pc);
            bus.OUT_RD_WE   = head_c.rd_we;
            bus.OUT_RD_ADDR = head_c.rd_addr;
            bus.OUT_RD_DATA = XLEN'(head_c.rd_data);
            bus.OUT_TS      = TS_W'(head_c.ts);
        end
    end

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Bench for pipeline_trace_monitor: a default-parameter instance plus a TS_W=4
// instance fed identical stimulus. Expected records are queued as retires are
// driven and compared when the head is accepted.
module tb_pipeline_trace_monitor;
    import pipeline_trace_pkg::*;

    logic clk;
    logic rst_n;

    pipeline_trace_if #(.XLEN(32), .PC_W(32), .DEPTH(16), .TS_W(16)) ifm ();
    pipeline_trace_if #(.XLEN(32), .PC_W(32), .DEPTH(16), .TS_W(4))  if4 ();

    pipeline_trace_monitor #(
        .XLEN(32), .PC_W(32), .DEPTH(16), .WATCH_REGS(6), .TS_W(16)
    ) u_dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifm.slave)
    );

    pipeline_trace_monitor #(
        .XLEN(32), .PC_W(32), .DEPTH(16), .WATCH_REGS(6), .TS_W(4)
    ) u_dut_ts4 (
        .CLK (clk),
        .RST (rst_n),
        .bus (if4.slave)
    );

    assign if4.EN        = ifm.EN;
    assign if4.MODE      = ifm.MODE;
    assign if4.TRIG_PC   = ifm.TRIG_PC;
    assign if4.RET_VALID = ifm.RET_VALID;
    assign if4.RET_PC    = ifm.RET_PC;
    assign if4.RD_WE     = ifm.RD_WE;
    assign if4.RD_ADDR   = ifm.RD_ADDR;
    assign if4.RD_DATA   = ifm.RD_DATA;
    assign if4.OUT_READY = ifm.OUT_READY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] ts;
    } exp_t;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        bit         rec;
    } watch_vec_t;

    exp_t        sb_q[$];
    exp_t        exp_rec;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tb_ts;
    logic [3:0]  prev_ts4;
    bit          have_prev4;
    bit          saw_wrap;

    // Free-running timestamp reference: cleared by reset, +1 every edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ret(input logic [31:0] pc, input logic we, input logic [4:0] addr,
                             input bit expect_rec);
        logic [31:0] data;
        data          = $urandom;
        ifm.RET_VALID = 1'b1;
        ifm.RET_PC    = pc;
        ifm.RD_WE     = we;
        ifm.RD_ADDR   = addr;
        ifm.RD_DATA   = data;
        if (expect_rec) sb_q.push_back('{pc, we, addr, data, tb_ts});
    endtask

    task automatic idle_ret();
        ifm.RET_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        ifm.OUT_READY = 1'b1;
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) step();
        step();
        step();
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        check({name, "_level0"}, 64'(ifm.LEVEL), 64'd0);
    endtask

    task automatic set_mode(input logic en, input logic [1:0] mode);
        ifm.EN   = en;
        ifm.MODE = mode;
        step();
        step();
    endtask

    // Scoreboard: compare each accepted head against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ifm.OUT_VALID && ifm.OUT_READY) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got record pc=%0h, required none", ifm.OUT_PC);
            end else begin
                exp_rec = sb_q.pop_front();
                check("sb_pc",   64'(ifm.OUT_PC),      64'(exp_rec.pc));
                check("sb_we",   64'(ifm.OUT_RD_WE),   64'(exp_rec.we));
                check("sb_addr", 64'(ifm.OUT_RD_ADDR), 64'(exp_rec.addr));
                check("sb_data", 64'(ifm.OUT_RD_DATA), 64'(exp_rec.data));
                check("sb_ts",   64'(ifm.OUT_TS),      64'(exp_rec.ts));
                check("sb4_pc",  64'(if4.OUT_PC),      64'(exp_rec.pc));
                check("sb4_ts",  64'(if4.OUT_TS),      64'(exp_rec.ts[3:0]));
                if (have_prev4 && prev_ts4 == 4'd15 && if4.OUT_TS == 4'd0) saw_wrap = 1'b1;
                prev_ts4   = if4.OUT_TS;
                have_prev4 = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        watch_vec_t wv[7];
        logic [31:0] pc;

        wv[0] = '{1'b1, 5'd0, 1'b0};
        wv[1] = '{1'b1, 5'd3, 1'b1};
        wv[2] = '{1'b1, 5'd7, 1'b0};
        wv[3] = '{1'b1, 5'd5, 1'b1};
        wv[4] = '{1'b0, 5'd3, 1'b0};
        wv[5] = '{1'b1, 5'd6, 1'b0};
        wv[6] = '{1'b1, 5'd1, 1'b1};

        have_prev4    = 1'b0;
        saw_wrap      = 1'b0;
        prev_ts4      = '0;
        rst_n         = 1'b0;
        ifm.EN        = 1'b0;
        ifm.MODE      = MODE_OFF;
        ifm.TRIG_PC   = '0;
        ifm.RET_VALID = 1'b0;
        ifm.RET_PC    = '0;
        ifm.RD_WE     = 1'b0;
        ifm.RD_ADDR   = '0;
        ifm.RD_DATA   = '0;
        ifm.OUT_READY = 1'b0;

        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(ifm.OUT_VALID),    64'd0);
        check("rst_level",     64'(ifm.LEVEL),        64'd0);
        check("rst_overflow",  64'(ifm.OVERFLOW_CNT), 64'd0);
        check("rst_triggered", 64'(ifm.TRIGGERED),    64'd0);
        check("rst_out_pc",    64'(ifm.OUT_PC),       64'd0);
        rst_n = 1'b1;
        step();

        // MODE 1: five back-to-back retires, head appears two cycles later
        ifm.OUT_READY = 1'b1;
        set_mode(1'b1, MODE_ALL);
        for (int i = 0; i < 5; i++) begin
            drive_ret(32'(i * 4), 1'b1, 5'(i + 1), 1'b1);
            step();
            if (i == 0) check("t1_latency_n1", 64'(ifm.OUT_VALID), 64'd0);
            if (i == 1) check("t1_latency_n2", 64'(ifm.OUT_VALID), 64'd1);
        end
        idle_ret();
        drain("t1");
        check("t1_overflow", 64'(ifm.OVERFLOW_CNT), 64'd0);
        set_mode(1'b0, MODE_OFF);

        // MODE 2: watched-register filter, table driven
        set_mode(1'b1, MODE_WATCH);
        for (int i = 0; i < 7; i++) begin
            drive_ret(32'h100 + 32'(i * 4), wv[i].we, wv[i].addr, wv[i].rec);
            step();
        end
        idle_ret();
        drain("t2");
        set_mode(1'b0, MODE_OFF);

        // MODE 3: trigger at 0x20, consumer stalled
        ifm.OUT_READY = 1'b0;
        ifm.TRIG_PC   = 32'h20;
        set_mode(1'b1, MODE_TRIG);
        check("t3_armed_not_trig", 64'(ifm.TRIGGERED), 64'd0);
        for (int i = 0; i <= 32; i++) begin
            pc = 32'(i * 4);
            drive_ret(pc, 1'b1, 5'(i), (pc >= 32'h20) && (pc <= 32'h5C));
            step();
            if (pc == 32'h1C) check("t3_armed_level", 64'(ifm.LEVEL), 64'd0);
            if (pc == 32'h20) check("t3_trig_low", 64'(ifm.TRIGGERED), 64'd0);
            if (pc == 32'h24) check("t3_trig_high", 64'(ifm.TRIGGERED), 64'd1);
        end
        idle_ret();
        step();
        step();
        check("t3_level_full",  64'(ifm.LEVEL),        64'd16);
        check("t3_overflow",    64'(ifm.OVERFLOW_CNT), 64'd0);
        check("t3_frozen_trig", 64'(ifm.TRIGGERED),    64'd1);
        drain("t3");
        ifm.EN = 1'b0;
        step();
        check("t3_trig_fall", 64'(ifm.TRIGGERED), 64'd0);
        step();

        // MODE 1 overflow: 20 retires into 16 entries
        ifm.OUT_READY = 1'b0;
        set_mode(1'b1, MODE_ALL);
        for (int i = 0; i < 20; i++) begin
            drive_ret(32'h200 + 32'(i * 4), 1'b1, 5'(i), i < 16);
            step();
        end
        idle_ret();
        step();
        step();
        check("t4_level_full", 64'(ifm.LEVEL),        64'd16);
        check("t4_overflow4",  64'(ifm.OVERFLOW_CNT), 64'd4);
        // push lands in the same cycle as a pop while full
        drive_ret(32'h300, 1'b1, 5'd9, 1'b1);
        step();
        idle_ret();
        ifm.OUT_READY = 1'b1;
        step();
        ifm.OUT_READY = 1'b0;
        step();
        check("t4_pushpop_level",    64'(ifm.LEVEL),        64'd16);
        check("t4_pushpop_overflow", 64'(ifm.OVERFLOW_CNT), 64'd4);
        for (int i = 0; i < 260; i++) begin
            drive_ret(32'h400, 1'b0, 5'd0, 1'b0);
            step();
        end
        idle_ret();
        step();
        step();
        check("t4_overflow_sat", 64'(ifm.OVERFLOW_CNT), 64'd255);
        drain("t4");
        set_mode(1'b0, MODE_OFF);

        // Async reset mid-capture with seven records buffered
        ifm.OUT_READY = 1'b0;
        set_mode(1'b1, MODE_ALL);
        for (int i = 0; i < 7; i++) begin
            drive_ret(32'h500 + 32'(i * 4), 1'b1, 5'(i), 1'b0);
            step();
        end
        idle_ret();
        step();
        step();
        check("t6_level7",    64'(ifm.LEVEL),     64'd7);
        check("t6_triggered", 64'(ifm.TRIGGERED), 64'd1);
        rst_n  = 1'b0;
        ifm.EN = 1'b0;
        #1;
        check("t6_valid_drop", 64'(ifm.OUT_VALID),    64'd0);
        check("t6_ovf_clear",  64'(ifm.OVERFLOW_CNT), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_rel_level", 64'(ifm.LEVEL),     64'd0);
        check("t6_rel_trig",  64'(ifm.TRIGGERED), 64'd0);
        check("t6_rel_valid", 64'(ifm.OUT_VALID), 64'd0);
        step();

        // TS_W=4 instance: timestamps wrap 15 -> 0 inside the record stream
        have_prev4    = 1'b0;
        saw_wrap      = 1'b0;
        ifm.OUT_READY = 1'b1;
        set_mode(1'b1, MODE_ALL);
        for (int i = 0; i < 20; i++) begin
            drive_ret(32'h600 + 32'(i * 4), 1'b1, 5'(i), 1'b1);
            step();
        end
        idle_ret();
        drain("t5");
        check("t5_ts4_wrap_seen", 64'(saw_wrap), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
